// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM state encoding,
// the number of byte lanes per instruction word and the largest legal word count.
// Ports: none (package only).
package imem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        HEADER = 3'd1,
        DATA   = 3'd2,
        WRITE  = 3'd3,
        CHECK  = 3'd4,
        DONE   = 3'd5,
        ERROR  = 3'd6
    } loaderState_t;

    // Four bytes make one instruction word.
    localparam int BYTE_LANES = 4;

    // Largest count byte accepted for a memory of 2**addrWidth words.
    function automatic int maxCount(input int addrWidth);
        return 1 << addrWidth;
    endfunction

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Packs four consecutive bytes into a little-endian word; the first byte lands in [7:0].
// Ports: clock/reset, clear (restart at lane 0), byteEn/byteIn (one accepted byte),
//        word (assembled word, meaningful while lastByte is high), lastByte (4th byte now).
module word_assembler
    import imem_loader_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        clear,
    input  logic        byteEn,
    input  logic [7:0]  byteIn,
    output logic [31:0] word,
    output logic        lastByte
);

    logic [1:0] laneIdx;
    logic [7:0] lane0;
    logic [7:0] lane1;
    logic [7:0] lane2;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            laneIdx <= 2'd0;
            lane0   <= 8'd0;
            lane1   <= 8'd0;
            lane2   <= 8'd0;
        end else if (clear) begin
            laneIdx <= 2'd0;
        end else if (byteEn) begin
            case (laneIdx)
                2'd0:    lane0 <= byteIn;
                2'd1:    lane1 <= byteIn;
                2'd2:    lane2 <= byteIn;
                default: ;
            endcase
            // Wraps 3 -> 0 on the 4th byte, ready for the next word.
            laneIdx <= laneIdx + 2'd1;
        end
    end

    // The 4th byte is taken straight from the input so the caller can register
    // the complete word on the same edge that accepts that byte.
    assign lastByte = byteEn && (laneIdx == 2'(BYTE_LANES - 1));
    assign word     = {byteIn, lane2, lane1, lane0};

endmodule

// File: rtl/imem_loader.sv
// Loads a program into instruction memory from a byte stream: count N, 4*N data bytes, checksum.
// Ports: clock/reset; start (load request); byte_valid/byte_data/byte_ready (byte stream);
//        wr_en/wr_addr/wr_data (memory write port); cpu_hold, done, error (status). All outputs registered.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_data,
    output logic                  byte_ready,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  error
);

    loaderState_t state;
    loaderState_t stateNext;

    logic [ADDR_WIDTH-1:0] wordIdx;
    logic [ADDR_WIDTH-1:0] lastIdx;
    logic [7:0]            checksum;

    logic        accept;
    logic        loadStart;
    logic        countBad;
    logic        dataByteEn;
    logic [31:0] asmWord;
    logic        asmLast;

    assign accept     = byte_valid && byte_ready;
    assign loadStart  = start && ((state == IDLE) || (state == DONE) || (state == ERROR));
    assign countBad   = (byte_data == 8'd0) || (int'({24'd0, byte_data}) > maxCount(ADDR_WIDTH));
    assign dataByteEn = accept && (state == DATA);

    word_assembler u_asm (
        .clock    (clock),
        .reset    (reset),
        .clear    (loadStart),
        .byteEn   (dataByteEn),
        .byteIn   (byte_data),
        .word     (asmWord),
        .lastByte (asmLast)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE, DONE, ERROR: begin
                if (start) stateNext = HEADER;
            end
            HEADER: begin
                if (accept) stateNext = countBad ? ERROR : DATA;
            end
            DATA: begin
                if (asmLast) stateNext = WRITE;
            end
            WRITE: begin
                stateNext = (wordIdx == lastIdx) ? CHECK : DATA;
            end
            CHECK: begin
                if (accept) stateNext = (byte_data == checksum) ? DONE : ERROR;
            end
            default: stateNext = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the
    // state they describe without any input-to-output combinational path.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wordIdx    <= '0;
            lastIdx    <= '0;
            checksum   <= 8'd0;
            byte_ready <= 1'b0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            cpu_hold   <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            if (loadStart) begin
                wordIdx  <= '0;
                checksum <= 8'd0;
            end
            if ((state == HEADER) && accept && !countBad) begin
                // Store N-1 so the final-word test is a plain equality; N<=2**ADDR_WIDTH fits.
                lastIdx <= ADDR_WIDTH'(byte_data - 8'd1);
            end
            if (dataByteEn) begin
                checksum <= checksum ^ byte_data;
            end
            if ((state == WRITE) && (wordIdx != lastIdx)) begin
                wordIdx <= wordIdx + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
            end
            if (asmLast) begin
                wr_addr <= wordIdx;
                wr_data <= asmWord;
            end
            byte_ready <= (stateNext == HEADER) || (stateNext == DATA) || (stateNext == CHECK);
            wr_en      <= (stateNext == WRITE);
            done       <= (stateNext == DONE);
            error      <= (stateNext == ERROR);
            cpu_hold   <= (stateNext != IDLE) && (stateNext != DONE);
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: a reference model turns each load into expected
// memory writes and a final status; a monitor checks every wr_en pulse against that queue.
// Ports: none (top-level bench).
module tb_imem_loader;

    logic        clock;
    logic        reset;
    logic        start;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        wr_en;
    logic [5:0]  wr_addr;
    logic [31:0] wr_data;
    logic        cpu_hold;
    logic        done;
    logic        error;

    int tests = 0;
    int fails = 0;

    logic [5:0]  expAddr[$];
    logic [31:0] expData[$];
    logic [7:0]  dataQ[$];

    imem_loader #(.DATA_WIDTH(32), .ADDR_WIDTH(6)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .error      (error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor: every write strobe must match the next write the model predicted.
    initial begin
        logic [5:0]  a;
        logic [31:0] d;
        forever begin
            @(negedge clock);
            if (wr_en === 1'b1) begin
                if (expData.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_write: addr %h data %h, expected no write", wr_addr, wr_data);
                end else begin
                    a = expAddr.pop_front();
                    d = expData.pop_front();
                    check("wr_addr", {26'd0, wr_addr}, {26'd0, a});
                    check("wr_data", wr_data, d);
                end
            end
        end
    end

    // All driver tasks enter and leave 1 time unit after a rising edge.
    task automatic sendByte(input logic [7:0] b, input int stallPct);
        int  waited = 0;
        bit  took = 0;
        if (stallPct > 0 && int'($urandom_range(99)) < stallPct) begin
            repeat ($urandom_range(1, 3)) @(posedge clock);
            #1;
        end
        byte_valid = 1'b1;
        byte_data  = b;
        while (!took && waited < 100) begin
            @(negedge clock);
            if (byte_ready) begin
                @(posedge clock);
                #1;
                took = 1;
            end else begin
                waited++;
            end
        end
        byte_valid = 1'b0;
        byte_data  = 8'($urandom);
        if (!took) begin
            tests++;
            fails++;
            $display("FAIL byte_accept: byte %h not accepted within 100 cycles, expected accept", b);
        end
    endtask

    task automatic pulseStart();
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        @(negedge clock);
        check("hold_after_start", {31'd0, cpu_hold}, 32'd1);
        check("done_cleared", {30'd0, done, error}, 32'd0);
        @(posedge clock);
        #1;
    endtask

    // Reference model: count N must be 1..64; data bytes pack little-endian into
    // words written at 0..N-1; the load succeeds only if the checksum is the XOR of all data bytes.
    task automatic runLoad(input string nm, input logic [7:0] n, input bit goodCk,
                           input int stallPct, input bit midStart);
        logic [7:0]  x = 8'd0;
        logic [31:0] w;
        bit          countOk;
        bit          ok;
        countOk = (n != 8'd0) && (n <= 8'd64);
        pulseStart();
        sendByte(n, stallPct);
        if (countOk) begin
            for (int i = 0; i < int'(n); i++) begin
                w = {dataQ[4*i+3], dataQ[4*i+2], dataQ[4*i+1], dataQ[4*i]};
                expAddr.push_back(6'(i));
                expData.push_back(w);
            end
            for (int j = 0; j < 4 * int'(n); j++) begin
                x = x ^ dataQ[j];
                if (midStart && j == 5) begin
                    start = 1'b1;
                    repeat (2) @(posedge clock);
                    #1;
                    start = 1'b0;
                end
                sendByte(dataQ[j], stallPct);
            end
            sendByte(goodCk ? x : (x ^ 8'h01), stallPct);
        end
        ok = countOk && goodCk;
        for (int c = 0; c < 200 && !(done || error); c++) @(negedge clock);
        @(negedge clock);
        $display("[TB] load %s: N=%0d expect %s", nm, n, ok ? "done" : "error");
        check({nm, "_done"}, {31'd0, done}, {31'd0, ok});
        check({nm, "_error"}, {31'd0, error}, {31'd0, !ok});
        check({nm, "_cpu_hold"}, {31'd0, cpu_hold}, {31'd0, !ok});
        check({nm, "_byte_ready"}, {31'd0, byte_ready}, 32'd0);
        check({nm, "_writes_left"}, expData.size(), 32'd0);
        @(posedge clock);
        #1;
    endtask

    task automatic fillWords(input logic [31:0] w[$]);
        dataQ.delete();
        foreach (w[i]) begin
            for (int k = 0; k < 4; k++) dataQ.push_back(w[i][8*k +: 8]);
        end
    endtask

    initial begin
        logic [31:0] words[$];
        logic [7:0]  n;

        reset      = 1'b1;
        start      = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'd0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        check("reset_byte_ready", {31'd0, byte_ready}, 32'd0);
        check("reset_wr_en", {31'd0, wr_en}, 32'd0);
        check("reset_wr_addr", {26'd0, wr_addr}, 32'd0);
        check("reset_wr_data", wr_data, 32'd0);
        check("reset_status", {29'd0, cpu_hold, done, error}, 32'd0);
        @(posedge clock);
        #1;

        // Normal load and bad checksum with the two-instruction program.
        words = '{32'h00000013, 32'h00100093};
        fillWords(words);
        runLoad("normal", 8'h02, 1'b1, 0, 1'b0);
        runLoad("bad_checksum", 8'h02, 1'b0, 0, 1'b0);

        // Illegal counts.
        runLoad("count_zero", 8'h00, 1'b1, 0, 1'b0);
        runLoad("count_0x41", 8'h41, 1'b1, 0, 1'b0);

        // Full depth with an incrementing word pattern.
        words.delete();
        for (int i = 0; i < 64; i++) words.push_back(32'h01000000 + 32'(i));
        fillWords(words);
        runLoad("full_depth", 8'h40, 1'b1, 0, 1'b0);

        // Stalled 3-word load with a stray start in the middle.
        words = '{$urandom, $urandom, $urandom};
        fillWords(words);
        runLoad("stall_midstart", 8'h03, 1'b1, 50, 1'b1);

        // Random loads.
        for (int r = 0; r < 4; r++) begin
            n = 8'($urandom_range(1, 8));
            words.delete();
            for (int i = 0; i < int'(n); i++) words.push_back($urandom);
            fillWords(words);
            runLoad("random", n, 1'($urandom_range(1)), 30, 1'b0);
        end

        // Reset after five data bytes of a 3-word load; only word 0 was written.
        pulseStart();
        sendByte(8'h03, 0);
        expAddr.push_back(6'd0);
        expData.push_back(32'h44332211);
        sendByte(8'h11, 0);
        sendByte(8'h22, 0);
        sendByte(8'h33, 0);
        sendByte(8'h44, 0);
        sendByte(8'h55, 0);
        #2;
        reset = 1'b1;
        #1;
        check("midreset_byte_ready", {31'd0, byte_ready}, 32'd0);
        check("midreset_wr", {31'd0, wr_en}, 32'd0);
        check("midreset_wr_addr", {26'd0, wr_addr}, 32'd0);
        check("midreset_wr_data", wr_data, 32'd0);
        check("midreset_status", {29'd0, cpu_hold, done, error}, 32'd0);
        check("midreset_writes_left", expData.size(), 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(posedge clock);
        #1;
        words = '{32'hDEADBEEF};
        fillWords(words);
        runLoad("after_reset", 8'h01, 1'b1, 0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter DATA_WIDTH, default 32, instruction word width; fixed at 32, since 4 bytes make one word.
REQ-002 Parameter ADDR_WIDTH, default 6, instruction-memory word-address width; depth is 2**ADDR_WIDTH.
REQ-003 clock  input  1  single clock; all state changes on posedge clock.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  level sampled each cycle; requests a new program load.
REQ-006 byte_valid  input  1  the byte source presents byte_data.
REQ-007 byte_data  input  8  the incoming load-stream byte.
REQ-008 byte_ready  output  1  the loader accepts byte_data this cycle.
REQ-009 wr_en  output  1  instruction-memory write strobe, one cycle per word.
REQ-010 wr_addr  output  ADDR_WIDTH  instruction-memory word address.
REQ-011 wr_data  output  DATA_WIDTH  assembled instruction word.
REQ-012 cpu_hold  output  1  holds the processor while the loader is active or has failed.
REQ-013 done  output  1  the last load completed with a good checksum.
REQ-014 error  output  1  the last load failed (bad count or checksum).

Function
REQ-015 A byte transfer occurs only when byte_valid and byte_ready are both 1 on a rising clock edge.
REQ-016 The stream format is: count byte N, then 4*N data bytes, then one checksum byte.
REQ-017 Data bytes are little-endian within a word; the first byte of each word goes to wr_data[7:0].
REQ-018 States: IDLE, HEADER, DATA, WRITE, CHECK, DONE, ERROR.
REQ-019 IDLE, DONE or ERROR with start=1 -> HEADER; the word index, byte counter and checksum clear to 0, done and error clear to 0, and cpu_hold goes to 1.
REQ-020 start is ignored in HEADER, DATA, WRITE and CHECK.
REQ-021 byte_ready is 1 only in HEADER, DATA and CHECK (registered, derived from state).
REQ-022 HEADER: an accepted byte with N=0 or N>2**ADDR_WIDTH -> ERROR; otherwise N is stored and the state goes to DATA.
REQ-023 DATA: each accepted byte XORs into the checksum and fills the next byte lane; the 4th byte of a word -> WRITE.
REQ-024 WRITE lasts exactly one cycle, with wr_en=1, wr_addr=word index and wr_data=assembled word.
REQ-025 The transition out of WRITE depends on the word index: index=N-1 -> CHECK; otherwise the index increments and the state returns to DATA.
REQ-026 The latency from the 4th data byte's accept edge to wr_en high is 1 cycle.
REQ-027 Outside WRITE, wr_en is 0; wr_addr and wr_data hold their last values.
REQ-028 CHECK: an accepted byte equal to the XOR of all data bytes -> DONE; any other value -> ERROR.
REQ-029 DONE drives done=1 and cpu_hold=0; ERROR drives error=1 and cpu_hold=1. Both states persist until the next start.
REQ-030 The word index never wraps; with N=2**ADDR_WIDTH the last write goes to address 2**ADDR_WIDTH-1.
REQ-031 The loader has no timeout; a stalled byte source leaves the state unchanged.

Reset
REQ-032 Asserting reset forces IDLE immediately, regardless of clock.
REQ-033 Reset values: byte_ready=0, wr_en=0, wr_addr=0, wr_data=0, cpu_hold=0, done=0, error=0; all counters and the checksum are 0.
REQ-034 Reset in mid-load abandons the load; words already written stay in memory, and the next load starts cleanly from address 0.

Structure
REQ-035 Package imem_loader_pkg holds the state encoding, the byte-lane count (4) and the maximum-count constant.
REQ-036 One sub-module, word_assembler, packs 4 bytes into a little-endian word and flags the 4th byte.
REQ-037 Outputs are registered; there are no combinational paths from inputs to outputs.

Verification
REQ-038 Normal load: start; bytes 02, 13,00,00,00, 93,00,10,00, checksum 0x90 -> writes 0x00000013 @0 and 0x00100093 @1; done=1; cpu_hold=0.
REQ-039 Bad checksum: same stream with checksum 0x91 -> both words written, error=1, done=0, cpu_hold=1.
REQ-040 Bad count: header 0x00, and separately header 0x41 -> ERROR, no wr_en pulse, byte_ready=0.
REQ-041 Full depth: N=0x40 with an incrementing word pattern -> 64 writes to addresses 0..63 with no wrap, then done=1.
REQ-042 Backpressure/stall: byte_valid toggles randomly during a 3-word load -> the same writes as the gap-free stream; a start pulse mid-load has no effect.
REQ-043 Reset mid-load: reset after 5 data bytes, then a fresh 1-word load (01, EF,BE,AD,DE, checksum 0x22) -> writes 0xDEADBEEF @0; done=1.
